dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter and sequencer for the single-ported 32-bit data memory. It sits between two requesters and the memory's clk/we/addr/wd/rd port. Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader. It serialises their accesses and registers each command into a fixed three-phase sequence. It returns read data, or an out-of-range error, through a per-port valid pulse.

## Interface
- `WIDTH`, 32: data and address width.
- `CAPACITY`, 128: memory depth in words. Addresses are word indices.
- `RR`, 1: 1 = round-robin, 0 = fixed priority (port 0 always wins).
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0`, `req1`  in  1: access request; held until the matching `gnt` is seen.
- `we0`, `we1`  in  1: 1 = write, 0 = read. Valid while `req` is high.
- `addr0`, `addr1`  in  WIDTH: word address.
- `wd0`, `wd1`  in  WIDTH: write data.
- `gnt0`, `gnt1`  out  1: one-cycle pulse meaning the command was latched. The requester may drop or change `req` from the next cycle.
- `rvalid0`, `rvalid1`  out  1: one-cycle completion pulse.
- `rdata`  out  WIDTH: shared return data, valid only while an `rvalid` is high.
- `rerr`  out  1: out-of-range flag, valid only with `rvalid`.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  WIDTH: memory address.
- `mem_wd`  out  WIDTH: memory write data.
- `mem_rd`  in  WIDTH: memory read data. The memory updates it on the falling edge from `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - With no request, stay in IDLE.
  - With any request, pick a winner, latch its `we`/`addr`/`wd` and port id, and go to ACCESS.
- **Winner selection**
  - If only one `req` is high, that port wins.
  - If both are high and `RR`=1, the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - If both are high and `RR`=0, port 0 wins.
  - The pointer updates on every latch.
- **ACCESS** (exactly one cycle)
  - `gnt` is high for the latched port only.
  - `mem_addr` and `mem_wd` drive the latched values.
  - `mem_we` = latched `we` AND in-range.
  - In range means `addr` < `CAPACITY`, compared at full WIDTH.
  - On the closing edge, capture `mem_rd` into `rdata` and go to RESP.
- **RESP** (exactly one cycle)
  - `rvalid` is high for the latched port.
  - `rerr` = NOT in-range.
  - Arbitration runs here exactly as in IDLE: a request present latches and goes to ACCESS, otherwise go to IDLE. This gives a two-cycle cadence under continuous load.
- **Return data rules**
  - Out-of-range read: `rdata` = 0 and no memory access effect.
  - Out-of-range write: `mem_we` stays 0.
  - Write: `rdata` is the previous contents of the word, because the memory read at the mid-cycle falling edge precedes the write at the closing edge.
- `req` inputs are ignored during ACCESS. A requester whose `gnt` pulsed must not be granted again for the same command; it deasserts `req` or presents a new command.
- **Outputs**
  - `gnt*`, `rvalid*`, `rerr` and `mem_we` are registered, or decoded from state plus latched registers.
  - There are no combinational paths from `req*` to any output.
  - `mem_addr`, `mem_wd` and `rdata` hold their last values when idle.
- **Reset** (`rst_n` low, any time, including mid-ACCESS): state goes to IDLE. All outputs and latched registers go to 0, the pointer goes to 1, and any in-flight transaction is dropped with no `rvalid`.

## Timing
- Single request at cycle 0 (IDLE):
  - cycle 1: `gnt` and `mem_we`.
  - cycle 2: `rvalid` with `rdata`.
- Contention, both ports requesting at cycle 0:
  - port 0 sees `gnt` in cycle 1 and `rvalid` in cycle 2.
  - port 1 is latched at the end of cycle 2 and sees `gnt` in cycle 3 and `rvalid` in cycle 4.
- `mem_we` is never high outside ACCESS. At most one `gnt` and at most one `rvalid` are high in any cycle.
- Worst-case wait for a held request with `RR`=1: one foreign transaction, i.e. `gnt` by cycle 3.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 → write `rvalid0` with `rdata`=0x00000000 (reset memory); read `rvalid0` with `rdata`=0xDEADBEEF; `rerr`=0 both.
- Both ports request reads (addr 1, 2) at cycle 0, held until granted, `RR`=1 → `gnt0` c1, `rvalid0` c2, `gnt1` c3, `rvalid1` c4. With both re-requesting continuously, grants alternate 1,0,1.
- `RR`=0, both held continuously → port 0 granted every two cycles; `gnt1` never asserts.
- Port 1 writes 0x12345678 to addr 200 (`CAPACITY` 128) → `mem_we` stays 0; `rvalid1` with `rerr`=1, `rdata`=0. A subsequent read of addr 72 (200 mod 128) returns the unchanged value.
- `rst_n` pulsed low during ACCESS of a write to addr 9 with 0xAA → no `rvalid`; all outputs 0 immediately; state IDLE; the next tie goes to port 0.
- Back-to-back port 0 requests → `gnt0` at cycles 1, 3, 5 and `rvalid0` at cycles 2, 4, 6; `mem_we` high only in ACCESS cycles of writes.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and three-phase
// sequencer in front of the single-ported data memory.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CAPACITY = 128,
  parameter int RR       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             rerr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  logic             lwe;
  logic             lport;
  logic             ptr;
  logic [WIDTH-1:0] laddr;
  logic [WIDTH-1:0] lwd;
  logic [WIDTH-1:0] rdata_q;

  logic             any;
  logic             win;
  logic             take;
  logic             in_range;

  assign any      = req0 | req1;
  assign in_range = laddr < WIDTH'(CAPACITY);

  // ptr holds the last granted port; the other one wins a tie
  always_comb begin
    win = 1'b0;
    unique case ({req1, req0})
      2'b11:   win = (RR != 0) ? ~ptr : 1'b0;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        take = any;
        if (any) state_n = ACCESS;
      end
      ACCESS: state_n = RESP;
      RESP: begin
        take    = any;
        state_n = any ? ACCESS : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lwe   <= 1'b0;
      lport <= 1'b0;
      ptr   <= 1'b1;
      laddr <= '0;
      lwd   <= '0;
    end else if (take) begin
      lwe   <= win ? we1 : we0;
      lport <= win;
      ptr   <= win;
      laddr <= win ? addr1 : addr0;
      lwd   <= win ? wd1 : wd0;
    end
  end

  // out-of-range accesses return zero instead of aliased data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= in_range ? mem_rd : '0;
    end
  end

  assign gnt0     = (state == ACCESS) && !lport;
  assign gnt1     = (state == ACCESS) && lport;
  assign rvalid0  = (state == RESP) && !lport;
  assign rvalid1  = (state == RESP) && lport;
  assign rerr     = (state == RESP) && !in_range;
  assign mem_we   = (state == ACCESS) && lwe && in_range;
  assign mem_addr = laddr;
  assign mem_wd   = lwd;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic checked against
// a transaction-level reference of the arbiter and memory.
module tb_dmem_arbiter;

  localparam int W   = 32;
  localparam int CAP = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic         rq [2];
  logic         wr [2];
  logic [W-1:0] ad [2];
  logic [W-1:0] dt [2];

  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic         rerr, mem_we;
  logic [W-1:0] rdata, mem_addr, mem_wd, mem_rd;

  logic         fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1;
  logic         fp_rerr, fp_mem_we;
  logic [W-1:0] fp_rdata, fp_mem_addr, fp_mem_wd;
  logic [W-1:0] zero = '0;

  dmem_arbiter #(.WIDTH(W), .CAPACITY(CAP), .RR(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(rq[0]), .req1(rq[1]),
    .we0(wr[0]), .we1(wr[1]),
    .addr0(ad[0]), .addr1(ad[1]),
    .wd0(dt[0]), .wd1(dt[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rerr(rerr),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.WIDTH(W), .CAPACITY(CAP), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(rq[0]), .req1(rq[1]),
    .we0(wr[0]), .we1(wr[1]),
    .addr0(ad[0]), .addr1(ad[1]),
    .wd0(dt[0]), .wd1(dt[1]),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1),
    .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rdata(fp_rdata), .rerr(fp_rerr),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_wd(fp_mem_wd), .mem_rd(zero)
  );

  // physical memory: read on falling edge, write on rising edge
  logic [W-1:0] mem [CAP] = '{default: '0};

  always @(negedge clk)
    mem_rd <= (mem_addr < CAP) ? mem[mem_addr[6:0]] : 32'hBAD0BAD0;

  always @(posedge clk)
    if (mem_we) mem[mem_addr[6:0]] <= mem_wd;

  typedef struct {
    bit           v;
    bit           p;
    bit           we;
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] r;
    bit           e;
  } txn_t;

  txn_t         acc, rsp;
  bit           last;
  logic [W-1:0] ref_mem [CAP] = '{default: '0};
  int           nvec = 0;
  int           nerr = 0;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic bit inr(logic [W-1:0] a);
    return a < CAP;
  endfunction

  task automatic model_reset();
    acc  = '{default: '0};
    rsp  = '{default: '0};
    last = 1'b1;
  endtask

  // check this cycle, then advance the model by one clock
  task automatic step();
    txn_t na, nr;
    bit   w;
    @(negedge clk);
    chk("gnt0", 32'(gnt0), 32'(acc.v && !acc.p));
    chk("gnt1", 32'(gnt1), 32'(acc.v && acc.p));
    chk("mem_we", 32'(mem_we), 32'(acc.v && acc.we && inr(acc.a)));
    if (acc.v) begin
      chk("mem_addr", mem_addr, acc.a);
      chk("mem_wd", mem_wd, acc.d);
    end
    chk("rvalid0", 32'(rvalid0), 32'(rsp.v && !rsp.p));
    chk("rvalid1", 32'(rvalid1), 32'(rsp.v && rsp.p));
    if (rsp.v) begin
      chk("rdata", rdata, rsp.r);
      chk("rerr", 32'(rerr), 32'(rsp.e));
    end
    nr = acc;
    if (acc.v) begin
      nr.e = !inr(acc.a);
      nr.r = nr.e ? '0 : ref_mem[acc.a[6:0]];
      if (acc.we && !nr.e) ref_mem[acc.a[6:0]] = acc.d;
    end
    na = '{default: '0};
    if (!acc.v && (rq[0] || rq[1])) begin
      w    = (rq[0] && rq[1]) ? ~last : rq[1];
      last = w;
      na.v = 1'b1;
      na.p = w;
      na.we = wr[w];
      na.a = ad[w];
      na.d = dt[w];
    end
    acc = na;
    rsp = nr;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit p, input bit w,
                      input logic [W-1:0] a, input logic [W-1:0] d,
                      output logic [W-1:0] r, output bit e,
                      output int n);
    wr[p] = w;
    ad[p] = a;
    dt[p] = d;
    rq[p] = 1'b1;
    n = 0;
    r = '0;
    e = 1'b0;
    while (!(acc.v && acc.p == p) && n < 8) begin
      step();
      n++;
    end
    rq[p] = 1'b0;
    chk("xfer_gnt", 32'(acc.v && acc.p == p), 32'd1);
    step();
    r = rdata;
    e = rerr;
  endtask

  task automatic new_cmd(input bit p);
    rq[p] = $urandom_range(3) != 0;
    wr[p] = $urandom_range(1) != 0;
    ad[p] = ($urandom_range(9) == 0) ? $urandom : $urandom_range(150);
    dt[p] = $urandom;
  endtask

  logic [W-1:0] r;
  bit           e;
  int           n;

  initial begin
    model_reset();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0;
      wr[p] = 1'b0;
      ad[p] = '0;
      dt[p] = '0;
    end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_rv", 32'({rvalid0, rvalid1}), 32'd0);
    chk("rst_we", 32'({mem_we, rerr}), 32'd0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_rdata", rdata, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // contention after reset: port 0 first
    rq[0] = 1'b1; ad[0] = 32'd1;
    rq[1] = 1'b1; ad[1] = 32'd2;
    step();
    chk("c1_gnt0", 32'(gnt0), 32'd1);
    rq[0] = 1'b0;
    step();
    chk("c2_rvalid0", 32'(rvalid0), 32'd1);
    step();
    chk("c3_gnt1", 32'(gnt1), 32'd1);
    rq[1] = 1'b0;
    step();
    chk("c4_rvalid1", 32'(rvalid1), 32'd1);

    xfer(0, 1, 32'd5, 32'hDEADBEEF, r, e, n);
    chk("wr5_lat", 32'(n), 32'd1);
    chk("wr5_rdata", r, 32'h0);
    chk("wr5_rerr", 32'(e), 32'd0);
    xfer(0, 0, 32'd5, 32'h0, r, e, n);
    chk("rd5_rdata", r, 32'hDEADBEEF);
    chk("rd5_rerr", 32'(e), 32'd0);

    xfer(0, 1, 32'd72, 32'h5555AAAA, r, e, n);
    xfer(1, 1, 32'd200, 32'h12345678, r, e, n);
    chk("oor_rerr", 32'(e), 32'd1);
    chk("oor_rdata", r, 32'h0);
    xfer(1, 0, 32'h80000048, 32'h0, r, e, n);
    chk("wide_rerr", 32'(e), 32'd1);
    xfer(1, 0, 32'd72, 32'h0, r, e, n);
    chk("rd72_rdata", r, 32'h5555AAAA);
    chk("rd72_rerr", 32'(e), 32'd0);

    // back-to-back writes from port 0
    rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'd10; dt[0] = $urandom;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("b2b_gnt0", 32'(gnt0), 32'(i % 2));
      chk("b2b_rv0", 32'(rvalid0), 32'(1 - i % 2));
      chk("b2b_we", 32'(mem_we), 32'(i % 2));
      if (i % 2 == 1) dt[0] = $urandom;
    end
    rq[0] = 1'b0;
    step();

    for (int c = 0; c < 400; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (acc.v && acc.p == p) begin
          new_cmd(p[0]);
        end else if (!rq[p] && $urandom_range(2) == 0) begin
          new_cmd(p[0]);
          rq[p] = 1'b1;
        end
      end
    end
    rq[0] = 1'b0;
    rq[1] = 1'b0;

    // reset in the ACCESS cycle of a write
    rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'd9; dt[0] = 32'hAA;
    n = 0;
    while (!(acc.v && !acc.p) && n < 8) begin
      step();
      n++;
    end
    chk("rst_acc_gnt0", 32'(gnt0), 32'd1);
    rq[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("mrst_rv", 32'({rvalid0, rvalid1}), 32'd0);
    chk("mrst_we", 32'({mem_we, rerr}), 32'd0);
    chk("mrst_addr", mem_addr, '0);
    chk("mrst_wd", mem_wd, '0);
    chk("mrst_rdata", rdata, '0);
    model_reset();
    #1 rst_n = 1'b1;
    step();

    // both held: RR alternates 0,1,0..; fixed priority only port 0
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'd3;
    rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'd4;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("fp_gnt0", 32'(fp_gnt0), 32'(i % 2));
      chk("fp_gnt1", 32'(fp_gnt1), 32'd0);
      if (i % 4 == 1) chk("rr_gnt0", 32'(gnt0), 32'd1);
      if (i % 4 == 3) chk("rr_gnt1", 32'(gnt1), 32'd1);
    end
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    step();
    step();
    xfer(1, 0, 32'd9, 32'h0, r, e, n);
    chk("rd9_rdata", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
